// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: widths, reset PC default, NOP encoding and buffer entry layout.
package instruction_fetch_pkg;

  localparam int unsigned IlenW          = 32;
  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
  localparam logic [31:0] PcInc          = 32'd4;
  localparam logic [31:0] NopInstr       = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]      pc;
    logic [IlenW-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs between fetch and decode; clear beats push.
module instruction_fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  fetch_entry_t           data_i,
  input  logic                   pop_i,
  output fetch_entry_t           data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !clear_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues credit-limited imem reads, buffers responses for decode
// and discards in-flight responses after a redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  localparam int unsigned CNT_W = $clog2(2 * DEPTH) + 1;

  logic [31:0]            pc_q, pc_d;
  logic [31:0]            rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]       outstanding_q, outstanding_d;
  logic [CNT_W-1:0]       discard_q, discard_d;
  logic                   fetch_en_q;
  logic [CNT_W-1:0]       live;
  logic [CNT_W:0]         used;
  logic                   credit;
  logic                   req_fire, rsp_accept, push, pop;
  logic [31:0]            target_pc;
  fetch_entry_t           push_entry, head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_empty, fifo_full;

  // Live requests plus buffered entries never exceed DEPTH, so every response has a slot.
  assign live   = outstanding_q - discard_q;
  assign used   = {1'b0, live} + (CNT_W + 1)'(fifo_count);
  assign credit = used < (CNT_W + 1)'(DEPTH);

  // fetch_en_q holds requests off while reset is asserted without using rst_n as data.
  assign imem_req_valid = fetch_en_q && !redirect_valid && credit;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_accept = imem_rsp_valid && (outstanding_q != '0);
  assign push       = rsp_accept && (discard_q == '0) && !redirect_valid;
  assign pop        = id_valid && id_ready;
  assign target_pc  = align_pc(redirect_pc);

  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

  assign id_valid = !fifo_empty;
  assign id_pc    = head.pc;
  assign id_instr = fifo_empty ? NopInstr : head.instr;

  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (req_fire && !rsp_accept) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!req_fire && rsp_accept) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end

    if (redirect_valid) begin
      pc_d      = target_pc;
      rsp_pc_d  = target_pc;
      discard_d = outstanding_q - CNT_W'(rsp_accept);
    end else begin
      if (req_fire) pc_d = pc_q + PcInc;
      if (push) rsp_pc_d = rsp_pc_q + PcInc;
      if (rsp_accept && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      fetch_en_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_en_q    <= 1'b1;
    end
  end

  instruction_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (redirect_valid),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_q != '0));

  discard_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    discard_q <= outstanding_q);

  push_has_slot: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: in-order memory model plus a scoreboard of expected PCs.
module tb_instruction_fetch;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          lat = 1;
  int          fire_count = 0;
  bit          consumer_en = 1'b0;
  bit          rand_ready = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory model and decode consumer: sample at negedge, drive 1 time unit after posedge.
  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_rsp_valid) begin
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
          pend_addr.push_back(imem_req_addr);
          pend_due.push_back(cyc + lat);
          fire_count++;
        end
        if (id_valid && id_ready && exp_q.size() != 0) begin
          check("id_pc", id_pc, exp_q[0]);
          check("id_instr", id_instr, mem_word(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      imem_rsp_valid = (pend_due.size() != 0) && (pend_due[0] <= cyc);
      imem_rsp_data  = imem_rsp_valid ? mem_word(pend_addr[0]) : 32'h0;
      imem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      id_ready       = consumer_en && (exp_q.size() != 0);
    end
  end

  task automatic run_expect(input logic [31:0] start, input int n, input int budget);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    consumer_en = 1'b1;
    for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
    check("drain_left", 32'(exp_q.size()), 32'd0);
    consumer_en = 1'b0;
    id_ready    = 1'b0;
    exp_q.delete();
  endtask

  // Outstanding count equals the memory model's pending requests at this point in the cycle.
  task automatic redirect(input logic [31:0] pc);
    logic [31:0] exp_disc;
    exp_disc       = 32'(pend_addr.size()) - (imem_rsp_valid ? 32'd1 : 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    check("req_valid_in_redirect", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    check("discard_after_redirect", 32'(dut.discard_q), exp_disc);
    check("id_valid_after_redirect", {31'd0, id_valid}, 32'd0);
    check("req_addr_after_redirect", imem_req_addr, {pc[31:2], 2'b00});
  endtask

  initial begin
    int waited;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) tick();
    check("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("reset_id_valid", {31'd0, id_valid}, 32'd0);
    check("reset_req_addr", imem_req_addr, 32'h0);
    rst_n = 1'b1;

    // Decode stalled: only DEPTH requests may be issued.
    repeat (10) tick();
    check("stall_fire_count", 32'(fire_count), DEPTH);
    check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("stall_id_valid", {31'd0, id_valid}, 32'd1);
    run_expect(32'h0, 8, 200);

    // Two requests in flight with long latency, then redirect: both responses dropped.
    lat = 4;
    redirect(32'h80);
    tick();
    tick();
    check("inflight_count", 32'(pend_addr.size()), 32'd2);
    check("inflight_rsp_idle", {31'd0, imem_rsp_valid}, 32'd0);
    redirect(32'h100);
    repeat (4) tick();
    check("discard_drained", 32'(dut.discard_q), 32'd0);
    run_expect(32'h100, 4, 200);

    // Redirect in the same cycle as a live response.
    repeat (6) tick();
    lat = 2;
    redirect(32'h140);
    waited = 0;
    while (!imem_rsp_valid && waited < 20) begin
      tick();
      waited++;
    end
    check("rsp_seen", {31'd0, imem_rsp_valid}, 32'd1);
    check("rsp_overlap_outstanding", 32'(pend_addr.size()), 32'd2);
    redirect(32'h180);
    run_expect(32'h180, 4, 200);

    // Back-to-back redirects: the second one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    check("b2b_id_valid", {31'd0, id_valid}, 32'd0);
    check("b2b_req_addr", imem_req_addr, 32'h300);
    run_expect(32'h300, 4, 200);

    // PC wrap and misaligned redirect target.
    redirect(32'hffff_fffc);
    run_expect(32'hffff_fffc, 3, 200);
    redirect(32'h103);
    run_expect(32'h100, 2, 200);

    // Random request backpressure with longer latency.
    rand_ready = 1'b1;
    lat = 3;
    redirect(32'h400);
    run_expect(32'h400, 12, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
